mem_stage: RTL

Memory-access stage directly downstream of the execute stage. It takes the EX result (ALU value or effective address `rs1 + imm`) and store data. Loads and stores are run against the data-memory port through a request/grant/response handshake, with byte/halfword alignment and sign extension. Every instruction is then registered toward write-back. While a memory access is outstanding, the stage holds the upstream pipeline through `stall_o`.

---
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the memory (slave):
// request/grant for the command phase, rvalid/rdata for the load response.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

interface mem_stage_if;
  logic              req;
  logic              we;
  logic [`XLEN-1:0]  addr;
  logic [`XLEN-1:0]  wdata;
  logic [3:0]        be;
  logic              gnt;
  logic              rvalid;
  logic [`XLEN-1:0]  rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: runs loads/stores over a req/gnt/rvalid bus with lane
// alignment and sign extension, stalls upstream while busy, registers results to WB.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module mem_stage (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [`INSTR_WIDTH-1:0]   instr_i,
  input  logic [`XLEN-1:0]          alu_res_i,
  input  logic [`XLEN-1:0]          rs2_rdata_i,
  input  logic [`REG_IDX_WIDTH-1:0] rd_idx_i,
  input  logic                      rd_en_i,
  input  logic [`XLEN-1:0]          rd_wdata_i,
  output logic                      stall_o,
  mem_stage_if.master               dmem,
  output logic                      wb_valid_o,
  output logic [`REG_IDX_WIDTH-1:0] wb_rd_idx_o,
  output logic                      wb_rd_en_o,
  output logic [`XLEN-1:0]          wb_rd_wdata_o,
  output logic                      misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = 4'b0011 << a;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [`XLEN-1:0] store_data(input logic [2:0] f3, input logic [`XLEN-1:0] rs2);
    case (f3[1:0])
      2'b00:   store_data = {4{rs2[7:0]}};
      2'b01:   store_data = {2{rs2[15:0]}};
      default: store_data = rs2;
    endcase
  endfunction

  function automatic logic [`XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                     input logic [`XLEN-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{a, 3'b000} +: 8];
    h = rdata[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = rdata;
    endcase
  endfunction

  logic [1:0]                state_q, state_d;
  logic [`XLEN-1:0]          addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]                fun3_q, fun3_d;
  logic [`REG_IDX_WIDTH-1:0] rd_idx_q, rd_idx_d, wb_idx_q, wb_idx_d;
  logic                      we_q, we_d;
  logic [3:0]                be_q, be_d;
  logic                      wb_valid_q, wb_valid_d, wb_en_q, wb_en_d, mis_q, mis_d;
  logic [`XLEN-1:0]          wb_data_q, wb_data_d;

  logic [6:0] opcode;
  logic [2:0] fun3;
  logic       is_load, is_store, misaligned;
  logic       unused_instr;

  assign opcode = instr_i[6:0];
  assign fun3   = instr_i[14:12];
  assign unused_instr = ^{instr_i[`INSTR_WIDTH-1:15], instr_i[11:7]};

  // Reserved fun3 encodings under the load/store opcodes fall through as non-memory ops.
  assign is_load  = (opcode == 7'b0000011) &&
                    (fun3 == 3'b000 || fun3 == 3'b001 || fun3 == 3'b010 ||
                     fun3 == 3'b100 || fun3 == 3'b101);
  assign is_store = (opcode == 7'b0100011) &&
                    (fun3 == 3'b000 || fun3 == 3'b001 || fun3 == 3'b010);
  assign misaligned = ((fun3[1:0] == 2'b01) && alu_res_i[0]) ||
                      ((fun3[1:0] == 2'b10) && (alu_res_i[1:0] != 2'b00));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fun3_d     = fun3_q;
    rd_idx_d   = rd_idx_q;
    we_d       = we_q;
    be_d       = be_q;
    wb_valid_d = 1'b0;
    mis_d      = 1'b0;
    wb_idx_d   = wb_idx_q;
    wb_en_d    = wb_en_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          wb_idx_d = rd_idx_i;
          if ((is_load || is_store) && !misaligned) begin
            state_d  = REQ;
            addr_d   = alu_res_i;
            fun3_d   = fun3;
            rd_idx_d = rd_idx_i;
            we_d     = is_store;
            wdata_d  = store_data(fun3, rs2_rdata_i);
            be_d     = store_be(fun3, alu_res_i[1:0]);
          end else if (is_load || is_store) begin
            wb_valid_d = 1'b1;
            mis_d      = 1'b1;
            wb_en_d    = 1'b0;
          end else begin
            wb_valid_d = 1'b1;
            wb_en_d    = rd_en_i && (rd_idx_i != '0);
            wb_data_d  = rd_wdata_i;
          end
        end
      end
      REQ: begin
        if (dmem.gnt) begin
          if (we_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_idx_d   = rd_idx_q;
            wb_en_d    = 1'b0;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (dmem.rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_idx_d   = rd_idx_q;
          wb_en_d    = (rd_idx_q != '0);
          wb_data_d  = load_extract(fun3_q, addr_q[1:0], dmem.rdata);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      fun3_q     <= '0;
      rd_idx_q   <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      wb_idx_q   <= '0;
      wb_en_q    <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fun3_q     <= fun3_d;
      rd_idx_q   <= rd_idx_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wb_valid_q <= wb_valid_d;
      mis_q      <= mis_d;
      wb_idx_q   <= wb_idx_d;
      wb_en_q    <= wb_en_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign stall_o       = (state_q != IDLE);
  assign dmem.req      = (state_q == REQ);
  assign dmem.we       = we_q;
  assign dmem.addr     = {addr_q[`XLEN-1:2], 2'b00};
  assign dmem.wdata    = wdata_q;
  assign dmem.be       = be_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_rd_idx_o   = wb_idx_q;
  assign wb_rd_en_o    = wb_en_q;
  assign wb_rd_wdata_o = wb_data_q;
  assign misalign_o    = mis_q;

endmodule
